// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between IF fetches and MEM data accesses.
// Optional misaligned-access rejection on the MEM port: define MEM_BUS_ARB_ALIGN_CHK_EN.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              mem_err_o,
    output logic              bus_ce_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              stall_req_o
);

    localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [3:0]    WAIT_INIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUSY_IF  = 2'd1,
        S_BUSY_MEM = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_wait;
    logic [SW-1:0]     r_starve;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_if_ack;
    logic              r_mem_ack;
    logic              r_mem_err;
    logic              r_bus_ce;
    logic              r_bus_we;
    logic [3:0]        r_bus_sel;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;

    logic              w_if_req;
    logic              w_mem_req;
    logic              w_grant_mem;
    logic              w_grant_if;
    logic              w_misalign;
    logic [SW-1:0]     w_starve_inc;

`ifdef MEM_BUS_ARB_ALIGN_CHK_EN
    function automatic logic f_misaligned(input logic [3:0] sel, input logic [1:0] addr_lo);
        logic res;
        case (sel)
            4'hF:       res = (addr_lo != 2'b00);
            4'h3, 4'hC: res = addr_lo[0];
            default:    res = 1'b0;
        endcase
        return res;
    endfunction

    assign w_misalign = f_misaligned(mem_sel_i, mem_addr_i[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // A requester still holding its line during its own ack cycle is not a new request.
    assign w_if_req     = if_req_i & ~r_if_ack;
    assign w_mem_req    = mem_req_i & ~r_mem_ack;
    assign w_grant_mem  = w_mem_req & ~(w_if_req & (r_starve == STARVE_MAX));
    assign w_grant_if   = w_if_req & ~w_grant_mem;
    assign w_starve_inc = (r_starve == STARVE_MAX) ? r_starve : r_starve + SW'(1);

    assign stall_req_o = (if_req_i & ~r_if_ack) | (mem_req_i & ~r_mem_ack);

    assign if_rdata_o  = r_if_rdata;
    assign mem_rdata_o = r_mem_rdata;
    assign if_ack_o    = r_if_ack;
    assign mem_ack_o   = r_mem_ack;
    assign mem_err_o   = r_mem_err;
    assign bus_ce_o    = r_bus_ce;
    assign bus_we_o    = r_bus_we;
    assign bus_sel_o   = r_bus_sel;
    assign bus_addr_o  = r_bus_addr;
    assign bus_wdata_o = r_bus_wdata;

    // Arbitration, bus-cycle sequencing and completion signalling.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait      <= 4'd0;
            r_starve    <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_mem_err   <= 1'b0;
            r_bus_ce    <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'h0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else begin
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            r_mem_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_mem && w_misalign) begin
                        r_mem_ack <= 1'b1;
                        r_mem_err <= 1'b1;
                    end else if (w_grant_mem) begin
                        r_state     <= S_BUSY_MEM;
                        r_wait      <= WAIT_INIT;
                        r_bus_ce    <= 1'b1;
                        r_bus_we    <= mem_we_i;
                        r_bus_sel   <= mem_sel_i;
                        r_bus_addr  <= mem_addr_i;
                        r_bus_wdata <= mem_wdata_i;
                        r_starve    <= w_if_req ? w_starve_inc : '0;
                    end else if (w_grant_if) begin
                        r_state     <= S_BUSY_IF;
                        r_wait      <= WAIT_INIT;
                        r_bus_ce    <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_sel   <= 4'hF;
                        r_bus_addr  <= if_addr_i;
                        r_bus_wdata <= '0;
                        r_starve    <= '0;
                    end else begin
                        r_starve <= '0;
                    end
                end
                S_BUSY_IF, S_BUSY_MEM: begin
                    if (r_wait == 4'd0) begin
                        if (r_state == S_BUSY_IF) begin
                            r_if_rdata <= bus_rdata_i;
                            r_if_ack   <= 1'b1;
                        end else begin
                            if (!r_bus_we) begin
                                r_mem_rdata <= bus_rdata_i;
                            end
                            r_mem_ack <= 1'b1;
                        end
                        r_bus_ce <= 1'b0;
                        r_bus_we <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_bus_ce <= 1'b0;
                    r_bus_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-schedule reference model.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WC = 2;
    localparam int SL = 3;
    localparam int NCYC = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic [DW-1:0] if_rdata_o;
    logic          if_ack_o;
    logic          mem_req_i;
    logic          mem_we_i;
    logic [3:0]    mem_sel_i;
    logic [AW-1:0] mem_addr_i;
    logic [DW-1:0] mem_wdata_i;
    logic [DW-1:0] mem_rdata_o;
    logic          mem_ack_o;
    logic          mem_err_o;
    logic          bus_ce_o;
    logic          bus_we_o;
    logic [3:0]    bus_sel_o;
    logic [AW-1:0] bus_addr_o;
    logic [DW-1:0] bus_wdata_o;
    logic [DW-1:0] bus_rdata_i;
    logic          stall_req_o;

    mem_bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o), .mem_err_o(mem_err_o),
        .bus_ce_o(bus_ce_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .stall_req_o(stall_req_o)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit misaligned(input logic [3:0] sel, input logic [1:0] lo);
`ifdef MEM_BUS_ARB_ALIGN_CHK_EN
        if (sel == 4'hF) return lo != 2'b00;
        if (sel == 4'h3 || sel == 4'hC) return lo[0];
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // Model: each transfer is a scheduled window of cycles plus an ack cycle.
    int            busy_last  = -1;
    int            if_ack_at  = -1;
    int            mem_ack_at = -1;
    bit            err_flag   = 1'b0;
    bit            xfer_is_if = 1'b0;
    bit            xfer_we    = 1'b0;
    bit            mem_rd     = 1'b0;
    int            starve     = 0;
    logic [AW-1:0] e_addr     = '0;
    logic [3:0]    e_sel      = 4'h0;
    logic [DW-1:0] e_wdata    = '0;
    logic [DW-1:0] e_if_rd    = '0;
    logic [DW-1:0] e_mem_rd   = '0;
    logic [DW-1:0] nxt_if_rd  = '0;
    logic [DW-1:0] nxt_mem_rd = '0;

    initial begin
        logic [3:0] sel_tab [7];
        bit in_win, eff_if, eff_mem, exp_stall;
        sel_tab = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
        rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        mem_sel_i = 4'h0; mem_addr_i = '0; mem_wdata_i = '0; bus_rdata_i = '0;
        repeat (2) @(posedge clk);
        for (int t = 0; t < NCYC; t++) begin
            @(posedge clk);
            #1;
            in_win = (t <= busy_last);
            if (t == if_ack_at) e_if_rd = nxt_if_rd;
            if (t == mem_ack_at && mem_rd) e_mem_rd = nxt_mem_rd;
            chk("if_ack",    64'(if_ack_o),    64'(t == if_ack_at));
            chk("mem_ack",   64'(mem_ack_o),   64'(t == mem_ack_at));
            chk("mem_err",   64'(mem_err_o),   64'(t == mem_ack_at && err_flag));
            chk("bus_ce",    64'(bus_ce_o),    64'(in_win));
            chk("bus_we",    64'(bus_we_o),    64'(in_win && xfer_we));
            chk("bus_addr",  64'(bus_addr_o),  64'(e_addr));
            chk("bus_sel",   64'(bus_sel_o),   64'(e_sel));
            chk("if_rdata",  64'(if_rdata_o),  64'(e_if_rd));
            chk("mem_rdata", 64'(mem_rdata_o), 64'(e_mem_rd));
            if (in_win && !xfer_is_if && xfer_we) chk("bus_wdata", 64'(bus_wdata_o), 64'(e_wdata));

            // Requesters: hold until acked, then maybe issue a new request.
            if (!if_req_i || if_ack_o) begin
                if_req_i  = ($urandom_range(0, 2) != 0);
                if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!mem_req_i || mem_ack_o) begin
                mem_req_i   = ($urandom_range(0, 2) != 0);
                mem_we_i    = $urandom_range(0, 1);
                mem_sel_i   = sel_tab[$urandom_range(0, 6)];
                mem_addr_i  = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
                mem_wdata_i = $urandom;
            end
            rst         = (t < 2) || ($urandom_range(0, 79) == 0);
            bus_rdata_i = $urandom;
            #1;
            exp_stall = (if_req_i && t != if_ack_at) || (mem_req_i && t != mem_ack_at);
            chk("stall", 64'(stall_req_o), 64'(exp_stall));

            // Model update for the coming edge.
            if (rst) begin
                busy_last = -1; if_ack_at = -1; mem_ack_at = -1; err_flag = 1'b0;
                xfer_we = 1'b0; starve = 0; e_addr = '0; e_sel = 4'h0; e_wdata = '0;
                e_if_rd = '0; e_mem_rd = '0; mem_rd = 1'b0;
            end else if (t == busy_last) begin
                if (xfer_is_if) begin
                    nxt_if_rd = bus_rdata_i;
                    if_ack_at = t + 1;
                end else begin
                    mem_rd     = !xfer_we;
                    nxt_mem_rd = bus_rdata_i;
                    err_flag   = 1'b0;
                    mem_ack_at = t + 1;
                end
            end else if (t > busy_last) begin
                eff_if  = if_req_i && (t != if_ack_at);
                eff_mem = mem_req_i && (t != mem_ack_at);
                if (eff_mem && !(eff_if && starve == SL)) begin
                    if (misaligned(mem_sel_i, mem_addr_i[1:0])) begin
                        mem_ack_at = t + 1;
                        err_flag   = 1'b1;
                        mem_rd     = 1'b0;
                    end else begin
                        busy_last  = t + 1 + WC;
                        xfer_is_if = 1'b0;
                        xfer_we    = mem_we_i;
                        e_addr     = mem_addr_i;
                        e_sel      = mem_sel_i;
                        e_wdata    = mem_wdata_i;
                        starve     = eff_if ? ((starve < SL) ? starve + 1 : SL) : 0;
                    end
                end else if (eff_if) begin
                    busy_last  = t + 1 + WC;
                    xfer_is_if = 1'b1;
                    xfer_we    = 1'b0;
                    e_addr     = if_addr_i;
                    e_sel      = 4'hF;
                    e_wdata    = '0;
                    starve     = 0;
                end else begin
                    starve = 0;
                end
            end
        end
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
